mac_rx_pkt_buffer: RTL and testbench

Store-and-forward packet buffer directly downstream of the MAC RX datapath. Accepts the per-byte RX stream with its end-of-packet CRC verdict and writes each packet into an internal byte RAM. Only packets whose CRC verdict is good and that fit entirely in free space are committed and released to the valid/ready consumer. Packets that fail CRC or overflow are rewound and dropped without ever becoming visible downstream.

---
 rtl/mac_rx_pkg.sv | 18 +
 rtl/rx_buf_ram.sv | 36 +++
 rtl/mac_rx_pkt_buffer.sv | 180 ++++++++++++++++++
 tb/tb_mac_rx_pkt_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_rx_pkg.sv
// Shared types and default sizing for the MAC RX store-and-forward packet buffer.
package mac_rx_pkg;

  localparam int DEFAULT_DEPTH = 2048;
  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } rx_buf_state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } rx_buf_word_t;

endpackage

// File: rtl/rx_buf_ram.sv
// Simple dual-port byte RAM, one write port and one synchronous read port.
// Only the read data register is reset; the array itself is not.
module rx_buf_ram
  import mac_rx_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  rx_buf_word_t  wr_word,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output rx_buf_word_t  rd_word
);

  rx_buf_word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // The read register doubles as the buffer's output register, so it holds until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_word <= '0;
    end else if (rd_en) begin
      rd_word <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/mac_rx_pkt_buffer.sv
// Store-and-forward RX packet buffer: commits good packets that fit, rewinds and drops the rest.
// Define RX_BUF_STATS_EN to implement the saturating ok/drop packet counters.
module mac_rx_pkt_buffer
  import mac_rx_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             in_crc_ok,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] pkt_ok_cnt,
  output logic [CNT_W-1:0] pkt_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
  localparam logic [AW:0] PTR_DEPTH = (AW + 1)'(DEPTH);

  rx_buf_state_e state, state_next;

  logic [AW:0]  wr_ptr, commit_ptr, commit_q, rd_ptr;
  logic         full;
  logic         wr_en, do_commit, do_rewind, ok_inc, drop_inc;
  logic         rd_issue;
  rx_buf_word_t wr_word, rd_word;

  assign full    = (wr_ptr - rd_ptr) == PTR_DEPTH;
  assign wr_word = '{last: in_last, data: in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, RECV: begin
        if (in_valid) begin
          if (in_last) begin
            state_next = IDLE;
          end else if (full) begin
            state_next = DROP;
          end else begin
            state_next = RECV;
          end
        end
      end
      DROP: begin
        if (in_valid && in_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A byte that would land on unread data is never written; the packet is rewound instead.
  always_comb begin
    wr_en     = 1'b0;
    do_commit = 1'b0;
    do_rewind = 1'b0;
    ok_inc    = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      IDLE, RECV: begin
        if (in_valid) begin
          if (full) begin
            do_rewind = 1'b1;
            drop_inc  = in_last;
          end else begin
            wr_en = 1'b1;
            if (in_last) begin
              if (in_crc_ok) begin
                do_commit = 1'b1;
                ok_inc    = 1'b1;
              end else begin
                do_rewind = 1'b1;
                drop_inc  = 1'b1;
              end
            end
          end
        end
      end
      DROP: begin
        drop_inc = in_valid && in_last;
      end
      default: ;
    endcase
  end

  // commit_q delays the reader's view of commit_ptr by one cycle, giving the two-edge release latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      commit_q   <= '0;
      rd_ptr     <= '0;
    end else begin
      if (do_rewind) begin
        wr_ptr <= commit_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_commit) begin
        commit_ptr <= wr_ptr + PTR_ONE;
      end
      commit_q <= commit_ptr;
      if (rd_issue) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  assign rd_issue = (rd_ptr != commit_q) && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_issue || (out_valid && !out_ready);
    end
  end

  rx_buf_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr[AW-1:0]),
    .wr_word(wr_word),
    .rd_en  (rd_issue),
    .rd_addr(rd_ptr[AW-1:0]),
    .rd_word(rd_word)
  );

  assign out_data = rd_word.data;
  assign out_last = rd_word.last;

`ifdef RX_BUF_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] ok_cnt, drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (ok_inc && (ok_cnt != '1)) begin
        ok_cnt <= ok_cnt + CNT_ONE;
      end
      if (drop_inc && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_ONE;
      end
    end
  end

  assign pkt_ok_cnt   = ok_cnt;
  assign pkt_drop_cnt = drop_cnt;
`else
  logic unused_stats;
  assign unused_stats = ok_inc ^ drop_inc;
  assign pkt_ok_cnt   = '0;
  assign pkt_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_rx_pkt_buffer.sv
// Self-checking bench for mac_rx_pkt_buffer: a default-depth instance and a 16-byte instance.
module tb_mac_rx_pkt_buffer;

  localparam int CNT_W = 16;
`ifdef RX_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid  [2];
  logic [7:0]       in_data   [2];
  logic             in_last   [2];
  logic             in_crc_ok [2];
  logic             out_valid [2];
  logic             out_ready [2];
  logic [7:0]       out_data  [2];
  logic             out_last  [2];
  logic [CNT_W-1:0] ok_cnt    [2];
  logic [CNT_W-1:0] drop_cnt  [2];

  int ready_mode [2];
  int exp_ok     [2];
  int exp_drop   [2];
  int checks = 0;
  int passes = 0;

  logic [8:0] exp0 [$];
  logic [8:0] exp1 [$];

  mac_rx_pkt_buffer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_data(in_data[0]), .in_last(in_last[0]), .in_crc_ok(in_crc_ok[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0]),
    .pkt_ok_cnt(ok_cnt[0]), .pkt_drop_cnt(drop_cnt[0])
  );

  mac_rx_pkt_buffer #(.DEPTH(16), .CNT_W(CNT_W)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_data(in_data[1]), .in_last(in_last[1]), .in_crc_ok(in_crc_ok[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1]),
    .pkt_ok_cnt(ok_cnt[1]), .pkt_drop_cnt(drop_cnt[1])
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [31:0] cnt_exp(int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  function automatic int qsize(int d);
    return (d == 0) ? exp0.size() : exp1.size();
  endfunction

  function automatic logic [8:0] qfront(int d);
    return (d == 0) ? exp0[0] : exp1[0];
  endfunction

  task automatic qpop(int d);
    if (d == 0) void'(exp0.pop_front());
    else        void'(exp1.pop_front());
  endtask

  task automatic qpush(int d, logic [8:0] w);
    if (d == 0) exp0.push_back(w);
    else        exp1.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      out_ready[d] = (ready_mode[d] == 2) ? 1'($urandom_range(0, 1)) : (ready_mode[d] == 1);
    end
  endtask

  // Reference: a packet is released, byte for byte, only if its verdict is good and it fits.
  task automatic send_pkt(int d, int len, bit crc, bit fits);
    logic [8:0] words [$];
    logic [7:0] b;
    bit         last;
    for (int i = 0; i < len; i++) begin
      b            = 8'($urandom);
      last         = (i == len - 1);
      in_valid[d]  = 1'b1;
      in_data[d]   = b;
      in_last[d]   = last;
      in_crc_ok[d] = last ? crc : 1'($urandom_range(0, 1));
      words.push_back({last, b});
      tick();
    end
    in_valid[d]  = 1'b0;
    in_last[d]   = 1'b0;
    in_crc_ok[d] = 1'b0;
    if (crc && fits) begin
      foreach (words[i]) qpush(d, words[i]);
      exp_ok[d]++;
    end else begin
      exp_drop[d]++;
    end
  endtask

  task automatic drain(int d, string tag);
    int n = 0;
    while ((qsize(d) != 0 || out_valid[d]) && n < 4000) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, qsize(d), 0);
    check({tag, "_ok_cnt"}, ok_cnt[d], cnt_exp(exp_ok[d]));
    check({tag, "_drop_cnt"}, drop_cnt[d], cnt_exp(exp_drop[d]));
  endtask

  // Every visible byte must be the oldest expected one, which also proves it holds while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (out_valid[d]) begin
          if (qsize(d) == 0) begin
            check($sformatf("spurious_out_valid%0d", d), out_valid[d], 0);
          end else begin
            check($sformatf("out_word%0d", d), {out_last[d], out_data[d]}, qfront(d));
            if (out_ready[d]) qpop(d);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]   = 1'b0;
      in_data[d]    = 8'h00;
      in_last[d]    = 1'b0;
      in_crc_ok[d]  = 1'b0;
      out_ready[d]  = 1'b1;
      ready_mode[d] = 1;
      exp_ok[d]     = 0;
      exp_drop[d]   = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_out_valid%0d", d), out_valid[d], 0);
      check($sformatf("rst_out_data%0d", d), out_data[d], 0);
      check($sformatf("rst_out_last%0d", d), out_last[d], 0);
      check($sformatf("rst_ok_cnt%0d", d), ok_cnt[d], 0);
      check($sformatf("rst_drop_cnt%0d", d), drop_cnt[d], 0);
    end
    rst_n = 1'b1;
    tick();

    // 64-byte good packet, first byte visible two edges after the last input edge
    send_pkt(0, 64, 1'b1, 1'b1);
    check("t1_lat_e0", out_valid[0], 0);
    tick();
    check("t1_lat_e1", out_valid[0], 0);
    tick();
    check("t1_lat_e2", out_valid[0], 1);
    drain(0, "t1");

    // bad CRC packet followed by a short good one
    send_pkt(0, 64, 1'b0, 1'b1);
    send_pkt(0, 10, 1'b1, 1'b1);
    drain(0, "t2");

    // single-byte packet that starts and ends in IDLE
    send_pkt(0, 1, 1'b1, 1'b1);
    drain(0, "t3");

    // back-to-back random packets with a randomly stalling consumer
    ready_mode[0] = 2;
    for (int p = 0; p < 20; p++) begin
      send_pkt(0, $urandom_range(1, 40), 1'b1, 1'b1);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain(0, "t4");
    ready_mode[0] = 1;

    // 16-byte buffer: a stalled 10-byte packet leaves no room for an 8-byte one
    ready_mode[1] = 0;
    tick();
    send_pkt(1, 10, 1'b1, 1'b1);
    send_pkt(1, 8, 1'b1, 1'b0);
    repeat (5) tick();
    check("t5_stalled_valid", out_valid[1], 1);
    ready_mode[1] = 1;
    drain(1, "t5");
    // longer than the buffer is always dropped; exactly the buffer size still fits
    send_pkt(1, 20, 1'b1, 1'b0);
    send_pkt(1, 16, 1'b1, 1'b1);
    drain(1, "t5b");

    // reset while a committed packet is partly read
    send_pkt(0, 30, 1'b1, 1'b1);
    repeat (6) tick();
    rst_n = 1'b0;
    exp0.delete();
    exp1.delete();
    for (int d = 0; d < 2; d++) begin
      exp_ok[d]   = 0;
      exp_drop[d] = 0;
    end
    #1;
    check("t6_rst_out_valid", out_valid[0], 0);
    check("t6_rst_ok_cnt", ok_cnt[0], 0);
    check("t6_rst_drop_cnt", drop_cnt[0], 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send_pkt(0, 12, 1'b1, 1'b1);
    drain(0, "t6");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
